// File: rtl/spi_master_tx.sv
// -----------------------------------------------------------------------------
// spi_master_tx
//
// Transmit shift stage of the SPI master. Pulls 32-bit words from the TX FIFO
// over a valid/ready handshake and shifts them out MSB-first, one bit per
// SCLK edge in standard mode or one nibble per edge in quad mode. Shifting is
// paced by tx_edge strobes from the SPI clock generator, which this block
// enables through clk_en_o while it has data to send.
//
// Ports:
//   HCLK           clock
//   HRESETn        asynchronous active-low reset
//   en             start pulse, only looked at while idle
//   tx_edge        one-cycle strobe per SCLK shift edge
//   en_quad_in     1 = quad (4-bit) mode, 0 = standard; captured at start
//   len_in         number of bits to transmit; captured at start
//   data_in        TX word from the FIFO
//   data_in_valid  FIFO has a word available
//   data_in_ready  word taken this cycle (combinational)
//   sdo            serial data out; only sdo[0] is used in standard mode
//   clk_en_o       enables the SCLK generator
//   tx_done        one-cycle pulse at the end of a transfer
// -----------------------------------------------------------------------------
module spi_master_tx #(
    parameter int LEN_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             en,
    input  logic             tx_edge,
    input  logic             en_quad_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic [31:0]      data_in,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    output logic [3:0]       sdo,
    output logic             clk_en_o,
    output logic             tx_done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRANSMIT  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t           state_reg;
    logic [31:0]      data_int_reg;
    // One bit wider than the length so that a 0xFFFF-bit quad transfer can
    // step past the length without wrapping back to a small value.
    logic [LEN_W:0]   counter_reg;
    logic             quad_reg;
    logic [LEN_W-1:0] len_reg;
    logic             clk_en_reg;
    logic             tx_done_reg;

    logic [LEN_W:0]   counter_step;
    logic [LEN_W:0]   counter_next;
    logic             last_edge;
    logic             word_boundary;
    logic [31:0]      data_shifted;
    logic             len_in_zero;

    // ------------------------------------------------------------------
    // Bit accounting for the current shift edge
    // ------------------------------------------------------------------
    assign counter_step  = quad_reg ? (LEN_W+1)'(4) : (LEN_W+1)'(1);
    assign counter_next  = counter_reg + counter_step;
    // Quad lengths that are not a multiple of four end on the first edge
    // that reaches or passes the length.
    assign last_edge     = (counter_next >= {1'b0, len_reg});
    // Every 32 bits the shift register is empty and needs a fresh word.
    assign word_boundary = (counter_next[4:0] == 5'd0);
    assign data_shifted  = quad_reg ? {data_int_reg[27:0], 4'b0000}
                                    : {data_int_reg[30:0], 1'b0};
    assign len_in_zero   = (len_in == '0);

    // ------------------------------------------------------------------
    // Handshake: a word is taken exactly in the cycle the FSM loads it
    // ------------------------------------------------------------------
    always_comb begin
        data_in_ready = 1'b0;
        case (state_reg)
            IDLE:      data_in_ready = en && !len_in_zero && data_in_valid;
            TRANSMIT:  data_in_ready = tx_edge && !last_edge && word_boundary
                                       && data_in_valid;
            WAIT_DATA: data_in_ready = data_in_valid;
            default:   data_in_ready = 1'b0;
        endcase
    end

    // Serial output straight from the top of the shift register
    assign sdo      = quad_reg ? data_int_reg[31:28] : {3'b000, data_int_reg[31]};
    assign clk_en_o = clk_en_reg;
    assign tx_done  = tx_done_reg;

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg    <= IDLE;
            data_int_reg <= '0;
            counter_reg  <= '0;
            quad_reg     <= 1'b0;
            len_reg      <= '0;
            clk_en_reg   <= 1'b0;
            tx_done_reg  <= 1'b0;
        end else begin
            // tx_done is a single-cycle pulse unless re-armed below
            tx_done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (en) begin
                        if (len_in_zero) begin
                            // Nothing to send: acknowledge without touching
                            // the FIFO or the SCLK generator.
                            tx_done_reg <= 1'b1;
                        end else begin
                            len_reg     <= len_in;
                            quad_reg    <= en_quad_in;
                            counter_reg <= '0;
                            if (data_in_valid) begin
                                data_int_reg <= data_in;
                                clk_en_reg   <= 1'b1;
                                state_reg    <= TRANSMIT;
                            end else begin
                                clk_en_reg <= 1'b0;
                                state_reg  <= WAIT_DATA;
                            end
                        end
                    end
                end

                TRANSMIT: begin
                    if (tx_edge) begin
                        counter_reg <= counter_next;
                        if (last_edge) begin
                            tx_done_reg  <= 1'b1;
                            clk_en_reg   <= 1'b0;
                            data_int_reg <= '0;
                            state_reg    <= IDLE;
                        end else if (word_boundary) begin
                            if (data_in_valid) begin
                                // Back-to-back word, no gap on the wire
                                data_int_reg <= data_in;
                            end else begin
                                // FIFO underrun: freeze SCLK until data arrives
                                clk_en_reg <= 1'b0;
                                state_reg  <= WAIT_DATA;
                            end
                        end else begin
                            data_int_reg <= data_shifted;
                        end
                    end
                end

                WAIT_DATA: begin
                    // SCLK is stopped here, so stray tx_edge strobes are ignored
                    if (data_in_valid) begin
                        data_int_reg <= data_in;
                        clk_en_reg   <= 1'b1;
                        state_reg    <= TRANSMIT;
                    end
                end

                default: begin
                    state_reg  <= IDLE;
                    clk_en_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_master_tx
//
// Directed bench for spi_master_tx. A small FIFO model feeds words over the
// valid/ready handshake; every word queued also pushes the sdo values it
// should produce into a scoreboard, which is popped and compared before each
// tx_edge strobe.
// -----------------------------------------------------------------------------
module tb_spi_master_tx;

    localparam int LEN_W = 16;

    logic             HCLK;
    logic             HRESETn;
    logic             en;
    logic             tx_edge;
    logic             en_quad_in;
    logic [LEN_W-1:0] len_in;
    logic [31:0]      data_in;
    logic             data_in_valid;
    logic             data_in_ready;
    logic [3:0]       sdo;
    logic             clk_en_o;
    logic             tx_done;

    spi_master_tx #(.LEN_W(LEN_W)) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .en            (en),
        .tx_edge       (tx_edge),
        .en_quad_in    (en_quad_in),
        .len_in        (len_in),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .sdo           (sdo),
        .clk_en_o      (clk_en_o),
        .tx_done       (tx_done)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    int          n_pass = 0;
    int          n_total = 0;
    int          words_consumed = 0;
    bit          take_flag = 1'b0;
    logic [31:0] word_q[$];
    logic [3:0]  sb[$];

    // Handshake monitor: a word is consumed when valid and ready are both
    // high in the same cycle.
    initial begin
        forever begin
            @(negedge HCLK);
            if (data_in_valid && data_in_ready) begin
                words_consumed++;
                take_flag = 1'b1;
            end
        end
    end

    // FIFO model: drops a consumed word after the clock edge and presents the
    // next queued one, if any.
    initial begin
        data_in_valid = 1'b0;
        data_in       = '0;
        forever begin
            @(posedge HCLK);
            #2;
            if (take_flag) begin
                data_in_valid = 1'b0;
                take_flag     = 1'b0;
            end
            if (!data_in_valid && word_q.size() > 0) begin
                data_in       = word_q.pop_front();
                data_in_valid = 1'b1;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation still running, observed no end, required finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Queue a FIFO word and the sdo values it should produce for nbits bits.
    task automatic push_word(input logic [31:0] w, input bit quad, input int nbits);
        logic [31:0] t;
        int          n;
        t = w;
        n = quad ? (nbits + 3) / 4 : nbits;
        word_q.push_back(w);
        for (int i = 0; i < n; i++) begin
            if (quad) begin
                sb.push_back(t[31:28]);
                t = t << 4;
            end else begin
                sb.push_back({3'b000, t[31]});
                t = t << 1;
            end
        end
    endtask

    // One idle cycle, compare sdo against the scoreboard, then strobe tx_edge.
    task automatic send_edge();
        logic [3:0] exp;
        tick();
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            exp = sb.pop_front();
            chk("sdo", 32'(sdo), 32'(exp));
        end
        tx_edge = 1'b1;
        tick();
        tx_edge = 1'b0;
    endtask

    task automatic start_xfer(input bit quad, input logic [LEN_W-1:0] len);
        en         = 1'b1;
        en_quad_in = quad;
        len_in     = len;
        tick();
        // Scramble the start parameters: they must be ignored after start.
        en         = 1'b0;
        en_quad_in = ~quad;
        len_in     = LEN_W'($urandom);
    endtask

    task automatic finish_xfer(input string tag, input int c0, input int nwords);
        chk({tag, "_done"}, 32'(tx_done), 32'd1);
        chk({tag, "_clk_en_off"}, 32'(clk_en_o), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(tx_done), 32'd0);
        chk({tag, "_words"}, 32'(words_consumed - c0), 32'(nwords));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    int c0;

    initial begin
        HRESETn    = 1'b0;
        en         = 1'b0;
        tx_edge    = 1'b0;
        en_quad_in = 1'b0;
        len_in     = '0;
        repeat (2) tick();
        chk("rst_sdo", 32'(sdo), 32'd0);
        chk("rst_clk_en", 32'(clk_en_o), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_ready", 32'(data_in_ready), 32'd0);
        HRESETn = 1'b1;
        tick();

        // Standard, 8 bits of 0xA5000000
        push_word(32'hA500_0000, 1'b0, 8);
        c0 = words_consumed;
        tick();
        start_xfer(1'b0, 16'd8);
        chk("std8_clk_en", 32'(clk_en_o), 32'd1);
        repeat (8) send_edge();
        finish_xfer("std8", c0, 1);
        $display("txn std8: words=%0d", words_consumed - c0);

        // Quad, 32 bits of 0x12345678
        push_word(32'h1234_5678, 1'b1, 32);
        c0 = words_consumed;
        tick();
        start_xfer(1'b1, 16'd32);
        chk("quad32_clk_en", 32'(clk_en_o), 32'd1);
        repeat (8) send_edge();
        finish_xfer("quad32", c0, 1);
        $display("txn quad32: words=%0d", words_consumed - c0);

        // Standard after quad: sdo[3:1] must be zero
        push_word(32'hFFFF_FFFF, 1'b0, 8);
        c0 = words_consumed;
        tick();
        start_xfer(1'b0, 16'd8);
        repeat (8) send_edge();
        finish_xfer("std_after_quad", c0, 1);
        $display("txn std_after_quad: words=%0d", words_consumed - c0);

        // Standard, 64 bits with a late second word
        push_word(32'h8C3E_51A7, 1'b0, 32);
        c0 = words_consumed;
        tick();
        start_xfer(1'b0, 16'd64);
        repeat (32) send_edge();
        chk("std64_wait_clk_en", 32'(clk_en_o), 32'd0);
        chk("std64_wait_done", 32'(tx_done), 32'd0);
        tx_edge = 1'b1;   // stray strobe while waiting: ignored
        tick();
        tx_edge = 1'b0;
        repeat (4) tick();
        chk("std64_wait_hold", 32'(clk_en_o), 32'd0);
        chk("std64_wait_ready", 32'(data_in_ready), 32'd0);
        push_word(32'h5A0F_F0C3, 1'b0, 32);
        for (int i = 0; i < 10 && !clk_en_o; i++) tick();
        chk("std64_resume_clk_en", 32'(clk_en_o), 32'd1);
        repeat (32) send_edge();
        finish_xfer("std64", c0, 2);
        $display("txn std64: words=%0d", words_consumed - c0);

        // len_in = 0 with a word waiting: acknowledged, nothing consumed.
        // The waiting word is then used by the quad 6-bit transfer.
        push_word(32'hABCD_EF01, 1'b1, 6);
        c0 = words_consumed;
        tick();
        en     = 1'b1;
        len_in = '0;
        tick();
        en = 1'b0;
        chk("len0_done", 32'(tx_done), 32'd1);
        chk("len0_clk_en", 32'(clk_en_o), 32'd0);
        chk("len0_words", 32'(words_consumed - c0), 32'd0);
        tick();
        chk("len0_done_pulse", 32'(tx_done), 32'd0);
        chk("len0_clk_en_after", 32'(clk_en_o), 32'd0);
        $display("txn len0: words=%0d", words_consumed - c0);

        // Quad, 6 bits: rounds up to 2 edges
        c0 = words_consumed;
        start_xfer(1'b1, 16'd6);
        chk("quad6_clk_en", 32'(clk_en_o), 32'd1);
        repeat (2) send_edge();
        finish_xfer("quad6", c0, 1);
        $display("txn quad6: words=%0d", words_consumed - c0);

        // Quad, 0xFFFF bits: 16384 edges, 2048 words, no counter wrap
        for (int i = 0; i < 2048; i++) push_word($urandom, 1'b1, 32);
        c0 = words_consumed;
        tick();
        start_xfer(1'b1, 16'hFFFF);
        repeat (16384) send_edge();
        finish_xfer("quad_max", c0, 2048);
        $display("txn quad_max: words=%0d", words_consumed - c0);

        // Reset after 10 edges of a 32-bit standard transfer
        push_word(32'hC3C3_C3C3, 1'b0, 32);
        tick();
        start_xfer(1'b0, 16'd32);
        repeat (10) send_edge();
        #2;
        HRESETn = 1'b0;
        #1;
        chk("midrst_sdo", 32'(sdo), 32'd0);
        chk("midrst_clk_en", 32'(clk_en_o), 32'd0);
        chk("midrst_done", 32'(tx_done), 32'd0);
        chk("midrst_ready", 32'(data_in_ready), 32'd0);
        sb.delete();
        tick();
        HRESETn = 1'b1;
        tick();
        chk("midrst_no_done", 32'(tx_done), 32'd0);
        $display("txn midrst: reset applied after 10 edges");

        // Clean restart from counter 0: 4 bits end after exactly 4 edges
        push_word(32'h9000_0000, 1'b0, 4);
        c0 = words_consumed;
        tick();
        start_xfer(1'b0, 16'd4);
        chk("restart_clk_en", 32'(clk_en_o), 32'd1);
        repeat (4) send_edge();
        finish_xfer("restart", c0, 1);
        $display("txn restart: words=%0d", words_consumed - c0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
